// File: rtl/sext_imm_pipe.sv
// Immediate generator for the ID stage: decodes inst[31:7] by format and buffers the
// result behind a registered-ready 2-entry skid buffer. Optional SEXT_IMM_PC_TARGET_EN adds pc+imm.
module sext_imm_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      din,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
`ifdef SEXT_IMM_PC_TARGET_EN
  input  logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  out_target,
`endif
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

  function automatic logic signed [XLEN-1:0] gen_imm(input logic [24:0] d, input logic [2:0] o);
    logic signed [XLEN-1:0] r;
    case (o)
      3'd0:    r = XLEN'($signed(d[24:13]));
      3'd1:    r = XLEN'($signed({d[24], d[0], d[23:18], d[4:1], 1'b0}));
      3'd2:    r = XLEN'($signed({d[24], d[12:5], d[13], d[23:14], 1'b0}));
      3'd3:    r = XLEN'($signed({d[24:18], d[4:0]}));
      3'd4:    r = XLEN'($signed({d[24:5], 12'b0}));
      3'd5:    r = XLEN'(d[12:8]);
      3'd6:    r = (XLEN == 64) ? XLEN'(d[18:13]) : XLEN'(d[17:13]);
      default: r = '0;
    endcase
    return r;
  endfunction

  occ_t                   st, st_nx;
  logic                   rdy_q;
  logic                   acc, drn;
  logic                   load_main, load_skid, skid_to_main;
  logic signed [XLEN-1:0] imm_p0;
  logic signed [XLEN-1:0] imm_p1, skid_imm_p1;
  logic [TAG_W-1:0]       tag_p1, skid_tag_p1;
  logic                   vld_p1;

  // ---- stage p0: decode at the input boundary
  assign imm_p0 = gen_imm(din, op);

  assign acc       = in_valid & rdy_q;
  assign vld_p1    = (st != EMPTY);
  assign drn       = vld_p1 & out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = vld_p1;
  assign out_imm   = imm_p1;
  assign out_tag   = tag_p1;

  always_comb begin
    st_nx        = st;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (st)
      EMPTY: if (acc) begin st_nx = ONE; load_main = 1'b1; end
      ONE: begin
        if (acc && drn)      load_main = 1'b1;
        else if (acc)        begin st_nx = TWO; load_skid = 1'b1; end
        else if (drn)        st_nx = EMPTY;
      end
      TWO: if (drn) begin st_nx = ONE; skid_to_main = 1'b1; end
      default: st_nx = EMPTY;
    endcase
    // A flushed cycle discards whatever was offered and leaves the data regs untouched
    if (flush) begin
      st_nx        = EMPTY;
      load_main    = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= EMPTY;
      rdy_q <= 1'b0;
    end else begin
      st    <= st_nx;
      rdy_q <= (st_nx != TWO);
    end
  end

  // ---- stage p1: main register drives the outputs, skid catches the overflow word
  always_ff @(posedge clk) begin
    if (rst) begin
      imm_p1 <= '0;
      tag_p1 <= '0;
    end else if (load_main) begin
      imm_p1 <= imm_p0;
      tag_p1 <= in_tag;
    end else if (skid_to_main) begin
      imm_p1 <= skid_imm_p1;
      tag_p1 <= skid_tag_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm_p1 <= imm_p0;
      skid_tag_p1 <= in_tag;
    end
  end

`ifdef SEXT_IMM_PC_TARGET_EN
  logic [XLEN-1:0] tgt_p0, tgt_p1, skid_tgt_p1;

  assign tgt_p0     = pc + imm_p0;
  assign out_target = tgt_p1;

  always_ff @(posedge clk) begin
    if (rst)               tgt_p1 <= '0;
    else if (load_main)    tgt_p1 <= tgt_p0;
    else if (skid_to_main) tgt_p1 <= skid_tgt_p1;
  end

  always_ff @(posedge clk) begin
    if (load_skid) skid_tgt_p1 <= tgt_p0;
  end
`endif

endmodule

// File: tb/tb_sext_imm_pipe.sv
// Directed bench for sext_imm_pipe: XLEN=32 and XLEN=64 instances share stimulus;
// expected values are hand-decoded RV immediates and FIFO handshake sequences.
module tb_sext_imm_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [24:0] din;
  logic [2:0]  op;
  logic [4:0]  in_tag;
  logic        in_ready, out_valid, in_ready64, out_valid64;
  logic [31:0] out_imm;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag, out_tag64;
`ifdef SEXT_IMM_PC_TARGET_EN
  logic [31:0] pc, out_target;
  logic [63:0] pc64, out_target64;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sext_imm_pipe #(.XLEN(32), .TAG_W(5)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .op(op), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm),
`ifdef SEXT_IMM_PC_TARGET_EN
    .pc(pc), .out_target(out_target),
`endif
    .out_tag(out_tag)
  );

  sext_imm_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .din(din), .op(op), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64),
`ifdef SEXT_IMM_PC_TARGET_EN
    .pc(pc64), .out_target(out_target64),
`endif
    .out_tag(out_tag64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] o, input logic [24:0] d, input logic [4:0] t);
    op = o; din = d; in_tag = t; in_valid = 1'b1;
  endtask

  // Single word into an empty buffer with out_ready high: visible next cycle, then drained
  task automatic imm_case(input string nm, input logic [2:0] o, input logic [24:0] d,
                          input logic [63:0] e32, input logic [63:0] e64);
    offer(o, d, 5'd7);
    tick();
    in_valid = 1'b0;
    chk({nm, "_vld"}, {63'd0, out_valid}, 64'd1);
    chk(nm, {32'd0, out_imm}, e32);
    chk({nm, "_x64"}, out_imm64, e64);
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    din = '0; op = '0; in_tag = '0;
`ifdef SEXT_IMM_PC_TARGET_EN
    pc = '0; pc64 = '0;
`endif
    tick(); tick(); tick();
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_imm", {32'd0, out_imm}, 64'd0);
    chk("rst_tag", {59'd0, out_tag}, 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

    // Format decode
    imm_case("addi_m1", 3'd0, 25'h1FFE001, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
    imm_case("i_pos",   3'd0, 25'h0FFE000, 64'h7FF, 64'h7FF);
    imm_case("beq_m4",  3'd1, 25'h1FC001D, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC);
    imm_case("sw_m8",   3'd3, 25'h1FC0018, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8);
    imm_case("jal_800", 3'd2, 25'h0002000, 64'h800, 64'h800);
    imm_case("jal_neg", 3'd2, 25'h1000000, 64'hFFF00000, 64'hFFFFFFFFFFF00000);
    imm_case("lui",     3'd4, 25'h02468A0, 64'h12345000, 64'h12345000);
    imm_case("lui_neg", 3'd4, 25'h1000000, 64'h80000000, 64'hFFFFFFFF80000000);
    imm_case("zimm31",  3'd5, 25'h0001F00, 64'h1F, 64'h1F);
    imm_case("shamt5",  3'd6, 25'h000A000, 64'h5, 64'h5);
    imm_case("shamt33", 3'd6, 25'h0042000, 64'h1, 64'h21);
    imm_case("op7",     3'd7, 25'h1FFFFFF, 64'h0, 64'h0);

    // Back-pressure: two words fit, third waits, then FIFO drain
    out_ready = 1'b0;
    offer(3'd0, 25'd1 << 13, 5'd1);
    chk("bp_rdy1", {63'd0, in_ready}, 64'd1);
    tick();
    offer(3'd0, 25'd2 << 13, 5'd2);
    chk("bp_rdy2", {63'd0, in_ready}, 64'd1);
    tick();
    offer(3'd0, 25'd3 << 13, 5'd3);
    chk("bp_rdy3", {63'd0, in_ready}, 64'd0);
    tick();
    chk("bp_hold_tag", {59'd0, out_tag}, 64'd1);
    chk("bp_hold_imm", {32'd0, out_imm}, 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_tag2", {59'd0, out_tag}, 64'd2);
    tick();
    in_valid = 1'b0;
    chk("bp_tag3", {59'd0, out_tag}, 64'd3);
    chk("bp_imm3", {32'd0, out_imm}, 64'd3);
    tick();
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Streaming at full rate
    for (int i = 0; i < 16; i++) begin
      offer(3'd0, 25'(i + 16) << 13, 5'(i + 16));
      tick();
      chk("stream_tag", {59'd0, out_tag}, 64'(i + 16));
      chk("stream_imm", {32'd0, out_imm}, 64'(i + 16));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_done", {63'd0, out_valid}, 64'd0);

    // Flush from TWO with a word offered
    out_ready = 1'b0;
    offer(3'd0, 25'd4 << 13, 5'd4); tick();
    offer(3'd0, 25'd5 << 13, 5'd5); tick();
    offer(3'd0, 25'd9 << 13, 5'd9); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_vld", {63'd0, out_valid}, 64'd0);
    chk("flush2_rdy", {63'd0, in_ready}, 64'd1);
    // Flush from ONE while a word is actually accepted
    offer(3'd0, 25'd6 << 13, 5'd6); tick();
    offer(3'd0, 25'd10 << 13, 5'd10); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush1_vld", {63'd0, out_valid}, 64'd0);
    tick();
    chk("flush1_gone", {63'd0, out_valid}, 64'd0);

    // Reset while full
    out_ready = 1'b0;
    offer(3'd0, 25'd11 << 13, 5'd11); tick();
    offer(3'd0, 25'd12 << 13, 5'd12); tick();
    in_valid = 1'b0;
    chk("full_rdy", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    tick();
    chk("rst2_vld", {63'd0, out_valid}, 64'd0);
    chk("rst2_imm", {32'd0, out_imm}, 64'd0);
    chk("rst2_tag", {59'd0, out_tag}, 64'd0);
    chk("rst2_rdy", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    tick();
    chk("rst2_rdy_after", {63'd0, in_ready}, 64'd1);
    chk("rst2_vld_after", {63'd0, out_valid}, 64'd0);

`ifdef SEXT_IMM_PC_TARGET_EN
    out_ready = 1'b1;
    pc = 32'h1000; pc64 = 64'h1000;
    offer(3'd1, 25'h1FC001D, 5'd1);
    tick();
    in_valid = 1'b0;
    chk("target", {32'd0, out_target}, 64'hFFC);
    chk("target64", out_target64, 64'hFFC);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
